cci_mpf_csr_event_counters: RTL

//   Consumes the single-cycle VTP event wires driven by the VTP shim and sums

---
 rtl/cci_mpf_csrs_pkg.sv | 17 +
 rtl/cci_mpf_prim_counter_split.sv | 52 +++++
 rtl/cci_mpf_csr_event_counters.sv | 94 +++++++++
 3 files changed

// File: rtl/cci_mpf_csrs_pkg.sv
// MPF CSR shared definitions: VTP event wire order, which is also the CSR
// index map used when reading the event counters.
package cci_mpf_csrs_pkg;

    localparam int unsigned CCI_MPF_VTP_N_EVENTS = 7;

    typedef enum logic [2:0] {
        VTP_EVENT_4KB_HIT_C0   = 3'd0,
        VTP_EVENT_4KB_HIT_C1   = 3'd1,
        VTP_EVENT_4KB_MISS     = 3'd2,
        VTP_EVENT_2MB_HIT_C0   = 3'd3,
        VTP_EVENT_2MB_HIT_C1   = 3'd4,
        VTP_EVENT_2MB_MISS     = 3'd5,
        VTP_EVENT_PT_WALK_BUSY = 3'd6
    } t_cci_mpf_vtp_event_idx;

endpackage

// File: rtl/cci_mpf_prim_counter_split.sv
// One wide counter split into registered low/high halves; the low-half wrap
// is carried into the high half one cycle later.
module cci_mpf_prim_counter_split #(
    parameter int unsigned CNT_WIDTH = 64,
    localparam int unsigned HALF = CNT_WIDTH / 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            inc,
    output logic [HALF-1:0] lo,
    output logic [HALF-1:0] hi,
    output logic            carry
);

    logic [HALF-1:0] lo_q, lo_d;
    logic [HALF-1:0] hi_q, hi_d;
    logic            carry_q, carry_d;

    // lo is zero right after a wrap, so carry_q can never be set two cycles in a row.
    always_comb begin
        lo_d    = lo_q;
        hi_d    = hi_q;
        carry_d = 1'b0;
        if (clear) begin
            lo_d = '0;
            hi_d = '0;
        end else begin
            if (inc) begin
                {carry_d, lo_d} = {1'b0, lo_q} + (HALF+1)'(1);
            end
            hi_d = hi_q + HALF'(carry_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_q    <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
        end
    end

    assign lo    = lo_q;
    assign hi    = hi_q;
    assign carry = carry_q;

endmodule

// File: rtl/cci_mpf_csr_event_counters.sv
// VTP event counters: registers the event wires, counts each into a split
// counter and serves indexed reads with a fixed two-cycle latency.
module cci_mpf_csr_event_counters
    import cci_mpf_csrs_pkg::*;
#(
    parameter int unsigned N_EVENTS  = CCI_MPF_VTP_N_EVENTS,
    parameter int unsigned CNT_WIDTH = 64,
    localparam int unsigned IDX_W = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1,
    localparam int unsigned HALF  = CNT_WIDTH / 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_EVENTS-1:0]  events,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 rd_req,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_rsp_valid,
    output logic [CNT_WIDTH-1:0] rd_rsp_data
);

    logic [N_EVENTS-1:0]  ev_q, ev_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [HALF-1:0]      s1_lo_q, s1_lo_d;
    logic [HALF-1:0]      s1_hi_q, s1_hi_d;
    logic                 s1_carry_q, s1_carry_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [CNT_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [HALF-1:0] cnt_lo    [N_EVENTS];
    logic [HALF-1:0] cnt_hi    [N_EVENTS];
    logic            cnt_carry [N_EVENTS];

    genvar g;
    for (g = 0; g < N_EVENTS; g++) begin : g_cnt
        cci_mpf_prim_counter_split #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .inc   (ev_q[g]),
            .lo    (cnt_lo[g]),
            .hi    (cnt_hi[g]),
            .carry (cnt_carry[g])
        );
    end

    // Snapshot lo/hi/carry together; the pending carry is folded in at stage 2
    // so a read that lands on a lo wrap still returns a coherent value.
    always_comb begin
        ev_d       = clear ? '0 : (events & {N_EVENTS{enable}});
        s1_valid_d = rd_req;
        s1_lo_d    = '0;
        s1_hi_d    = '0;
        s1_carry_d = 1'b0;
        for (int unsigned i = 0; i < N_EVENTS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                s1_lo_d    = cnt_lo[i];
                s1_hi_d    = cnt_hi[i];
                s1_carry_d = cnt_carry[i];
            end
        end
        rsp_valid_d = s1_valid_q;
        rsp_data_d  = rsp_data_q;
        if (s1_valid_q) begin
            rsp_data_d = {s1_hi_q + HALF'(s1_carry_q), s1_lo_q};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_lo_q     <= '0;
            s1_hi_q     <= '0;
            s1_carry_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ev_q        <= ev_d;
            s1_valid_q  <= s1_valid_d;
            s1_lo_q     <= s1_lo_d;
            s1_hi_q     <= s1_hi_d;
            s1_carry_q  <= s1_carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_data  = rsp_data_q;

endmodule
